// File: rtl/tcm_encoder_pkg.sv
// Shared trellis definition for the 4-state rate-2/3 8-PSK TCM encoder.
// Decoder-side models import this to stay consistent with the encoder.
package tcm_encoder_pkg;

    localparam int SYM_W = 3;
    localparam int ST_W  = 2;

    typedef enum logic [1:0] {
        DATA  = 2'd0,
        TAIL1 = 2'd1,
        TAIL2 = 2'd2
    } fsm_e;

    typedef struct packed {
        logic [SYM_W-1:0] sym;
        logic [ST_W-1:0]  nxt;
    } step_t;

    // Label is {x2, x1, s0}; next state is {s0, s1 ^ x1}.
    function automatic step_t trellis_step(
        input logic [ST_W-1:0] st,
        input logic            x2,
        input logic            x1
    );
        step_t r;
        r.sym = {x2, x1, st[0]};
        r.nxt = {st[0], st[1] ^ x1};
        return r;
    endfunction

endpackage

// File: rtl/tcm_encoder_out_reg.sv
// Single-entry output symbol register with valid/ready handshake.
// The owner only asserts load_i when can_load_o is high.
module tcm_out_reg
    import tcm_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [SYM_W-1:0] sym_i,
    input  logic             last_i,
    input  logic             out_ready_i,
    output logic             out_valid_o,
    output logic [SYM_W-1:0] out_sym_o,
    output logic             out_last_o,
    output logic             can_load_o
);

    logic             valid_q;
    logic [SYM_W-1:0] sym_q;
    logic             last_q;

    assign can_load_o  = !valid_q || out_ready_i;
    assign out_valid_o = valid_q;
    assign out_sym_o   = sym_q;
    assign out_last_o  = last_q;

    // Capture a new symbol, or go empty when drained without a refill.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            sym_q   <= '0;
            last_q  <= 1'b0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            sym_q   <= sym_i;
            last_q  <= last_i;
        end else if (out_ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/tcm_encoder.sv
// 4-state rate-2/3 trellis-coded 8-PSK encoder with optional
// two-symbol trellis termination after each frame.
module tcm_encoder
    import tcm_encoder_pkg::*;
#(
    parameter int TAIL_EN = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_sym,
    output logic             out_last,
    output logic [ST_W-1:0]  enc_state
);

    localparam bit TAIL = (TAIL_EN != 0);

    fsm_e            fsm_q, fsm_d;
    logic [ST_W-1:0] st_q, st_d;
    logic            can_load;
    logic            load;
    logic            x2, x1;
    logic            last_d;
    step_t           stp;

    assign in_ready  = (fsm_q == DATA) && can_load;
    assign enc_state = st_q;

    // Pick the symbol source (data or tail) and the next FSM/trellis state.
    always_comb begin
        fsm_d  = fsm_q;
        load   = 1'b0;
        x2     = 1'b0;
        x1     = 1'b0;
        last_d = 1'b0;
        unique case (fsm_q)
            DATA: begin
                if (in_valid && in_ready) begin
                    load   = 1'b1;
                    x2     = in_data[1];
                    x1     = in_data[0];
                    last_d = !TAIL && in_last;
                    if (TAIL && in_last) fsm_d = TAIL1;
                end
            end
            TAIL1: begin
                if (can_load) begin
                    load  = 1'b1;
                    x1    = st_q[1];
                    fsm_d = TAIL2;
                end
            end
            TAIL2: begin
                if (can_load) begin
                    load   = 1'b1;
                    x1     = st_q[1];
                    last_d = 1'b1;
                    fsm_d  = DATA;
                end
            end
            default: fsm_d = DATA;
        endcase
        stp  = trellis_step(st_q, x2, x1);
        st_d = load ? stp.nxt : st_q;
    end

    // Frame FSM and trellis state advance only when a symbol is loaded.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q <= DATA;
            st_q  <= '0;
        end else begin
            fsm_q <= fsm_d;
            st_q  <= st_d;
        end
    end

    tcm_out_reg u_out (
        .clk         (clk),
        .reset       (reset),
        .load_i      (load),
        .sym_i       (stp.sym),
        .last_i      (last_d),
        .out_ready_i (out_ready),
        .out_valid_o (out_valid),
        .out_sym_o   (out_sym),
        .out_last_o  (out_last),
        .can_load_o  (can_load)
    );

endmodule

// File: tb/tb_tcm_encoder.sv
// Self-checking bench: two encoders (no tail / with tail) share stimulus,
// each tracked by its own reference model and scoreboard queue.
module tb_tcm_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic       in_valid;
    logic       in_last;
    logic       out_ready;
    logic [1:0] in_data;

    logic       ir [2];
    logic       ov [2];
    logic       ol [2];
    logic [2:0] os [2];
    logic [1:0] es [2];

    tcm_encoder #(.TAIL_EN(0)) u0 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (ir[0]),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (ov[0]),
        .out_ready (out_ready),
        .out_sym   (os[0]),
        .out_last  (ol[0]),
        .enc_state (es[0])
    );

    tcm_encoder #(.TAIL_EN(1)) u1 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (ir[1]),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (ov[1]),
        .out_ready (out_ready),
        .out_sym   (os[1]),
        .out_last  (ol[1]),
        .enc_state (es[1])
    );

    int nvec = 0;
    int nmis = 0;

    int         mfsm [2];
    logic [1:0] mst  [2];
    bit         mval [2];

    // entries are {last, sym}
    logic [3:0] q0 [$];
    logic [3:0] q1 [$];
    logic [3:0] lg0 [$];
    logic [3:0] lg1 [$];

    int ex [8];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic sb_push(input int k, input logic [3:0] v);
        if (k == 0) q0.push_back(v);
        else q1.push_back(v);
    endtask

    task automatic step();
        logic [3:0] e;
        logic [3:0] o;
        bit         ld;
        logic       x1;
        logic       x2;
        int         qs;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.out_valid", k), ov[k], mval[k]);
            chk($sformatf("u%0d.in_ready", k), ir[k],
                (mfsm[k] == 0) && (!mval[k] || out_ready));
            chk($sformatf("u%0d.enc_state", k), es[k], mst[k]);
            if (ov[k] && out_ready) begin
                o = {ol[k], os[k]};
                if (k == 0) lg0.push_back(o);
                else lg1.push_back(o);
                qs = (k == 0) ? q0.size() : q1.size();
                if (qs == 0) begin
                    chk($sformatf("u%0d.sb_underflow", k), qs, 1);
                end else begin
                    e = (k == 0) ? q0.pop_front() : q1.pop_front();
                    chk($sformatf("u%0d.sym_last", k), o, e);
                end
            end
            ld = !mval[k] || out_ready;
            if (mfsm[k] == 0) begin
                if (in_valid && ld) begin
                    x2 = in_data[1];
                    x1 = in_data[0];
                    sb_push(k, {(k == 0) && in_last, x2, x1, mst[k][0]});
                    mst[k]  = {mst[k][0], mst[k][1] ^ x1};
                    mval[k] = 1'b1;
                    if (in_last && k == 1) mfsm[k] = 1;
                end else if (out_ready) begin
                    mval[k] = 1'b0;
                end
            end else if (ld) begin
                x1 = mst[k][1];
                sb_push(k, {mfsm[k] == 2, 1'b0, x1, mst[k][0]});
                mst[k]  = {mst[k][0], mst[k][1] ^ x1};
                mval[k] = 1'b1;
                mfsm[k] = (mfsm[k] == 1) ? 2 : 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic rst();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mfsm[k] = 0;
            mst[k]  = 2'b00;
            mval[k] = 1'b0;
        end
        q0.delete();
        q1.delete();
        lg0.delete();
        lg1.delete();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.rst_valid", k), ov[k], 0);
            chk($sformatf("u%0d.rst_sym", k), os[k], 0);
            chk($sformatf("u%0d.rst_last", k), ol[k], 0);
            chk($sformatf("u%0d.rst_state", k), es[k], 0);
            chk($sformatf("u%0d.rst_ready", k), ir[k], 1);
        end
    endtask

    task automatic send(input logic [1:0] d, input logic l);
        in_data  = d;
        in_last  = l;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cmp_log(input string tag, input int k, input int n,
                           input int exp [8]);
        int sz;
        sz = (k == 0) ? lg0.size() : lg1.size();
        chk({tag, ".len"}, sz, n);
        for (int i = 0; i < n && i < sz; i++) begin
            chk($sformatf("%s[%0d]", tag, i),
                (k == 0) ? lg0[i] : lg1[i], exp[i]);
        end
    endtask

    initial begin
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 2'b00;
        in_last   = 1'b0;
        out_ready = 1'b1;

        // basic frame
        rst();
        send(2'b01, 1'b0);
        send(2'b10, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        idle(4);
        ex = '{2, 5, 0, 3, 3, 10, 0, 0};
        cmp_log("basic.u1", 1, 6, ex);
        ex = '{2, 5, 0, 11, 0, 0, 0, 0};
        cmp_log("basic.u0", 0, 4, ex);
        chk("basic.u1.end_state", es[1], 0);
        chk("basic.u0.end_state", es[0], 3);

        // single-symbol frame
        rst();
        send(2'b11, 1'b1);
        idle(3);
        ex = '{6, 1, 10, 0, 0, 0, 0, 0};
        cmp_log("single.u1", 1, 3, ex);
        ex = '{14, 0, 0, 0, 0, 0, 0, 0};
        cmp_log("single.u0", 0, 1, ex);

        // backpressure after first symbol
        rst();
        send(2'b01, 1'b0);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 2'b10;
        repeat (3) begin
            step();
            chk("bp.hold_sym", os[1], 2);
            chk("bp.hold_ready", ir[1], 0);
        end
        out_ready = 1'b1;
        send(2'b10, 1'b0);
        send(2'b00, 1'b0);
        send(2'b01, 1'b1);
        idle(4);
        ex = '{2, 5, 0, 3, 3, 10, 0, 0};
        cmp_log("bp.u1", 1, 6, ex);

        // no-tail variant keeps its state across frames
        rst();
        send(2'b01, 1'b0);
        send(2'b10, 1'b1);
        idle(3);
        ex = '{2, 13, 0, 0, 0, 0, 0, 0};
        cmp_log("notail.u0", 0, 2, ex);
        chk("notail.u0.state", es[0], 2);
        ex = '{2, 5, 2, 8, 0, 0, 0, 0};
        cmp_log("notail.u1", 1, 4, ex);
        send(2'b00, 1'b0);
        idle(1);
        chk("notail.u0.next_state", es[0], 1);

        // reset while in TAIL1
        rst();
        send(2'b01, 1'b0);
        send(2'b10, 1'b1);
        rst();
        idle(4);
        chk("tailrst.u1.no_tail", lg1.size(), 0);

        // random traffic with random backpressure
        rst();
        repeat (400) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 2'($urandom_range(0, 3));
            in_last   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        idle(5);
        chk("rand.u0.drained", q0.size(), 0);
        chk("rand.u1.drained", q1.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/tcm_encoder.md
TCM_ENCODER -- requirements
Module: tcm_encoder

Interface
REQ-001 Parameter TAIL_EN, default 1: 1 = append two trellis-termination symbols after each frame; 0 = no tail.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  in_data/in_last valid this cycle.
REQ-005 in_ready  output  1  encoder accepts input this cycle.
REQ-006 in_data  input  2  {x2 uncoded bit, x1 coded bit}.
REQ-007 in_last  input  1  final input pair of the current frame.
REQ-008 out_valid  output  1  out_sym/out_last valid.
REQ-009 out_ready  input  1  downstream accepts the symbol this cycle.
REQ-010 out_sym  output  3  8-PSK symbol label {z2,z1,z0}, 0..7.
REQ-011 out_last  output  1  final symbol of the frame (tail or data).
REQ-012 enc_state  output  2  current trellis state {s1,s0}, for debug and bench.

Function
REQ-013 Trellis is 4-state, rate 2/3. Symbol = {x2, x1, s0}. Next state: s1' = s0, s0' = s1 XOR x1.
REQ-014 FSM states: DATA, TAIL1, TAIL2.
REQ-015 Transitions:
- DATA -> TAIL1 on an accepted input with in_last=1 and TAIL_EN=1.
- TAIL1 -> TAIL2 when the tail-1 symbol is loaded.
- TAIL2 -> DATA when the tail-2 symbol is loaded.
REQ-016 Tail symbols use x2=0 and x1=s1 (current state), so the trellis state is 00 after TAIL2.
REQ-017 Output holds one symbol register. A symbol is "loaded" when the register is empty or out_ready=1 in the same cycle.
REQ-018 in_ready = (FSM==DATA) AND (NOT out_valid OR out_ready).
REQ-019 Latency: an input accepted in cycle N appears on out_sym with out_valid=1 in cycle N+1.
REQ-020 While out_valid=1 and out_ready=0: out_sym, out_last, enc_state and FSM are all held.
REQ-021 In TAIL1 and TAIL2 a tail symbol is loaded whenever the load condition of REQ-017 holds. No input is consumed in these states.
REQ-022 out_last=1 on:
- the TAIL2 symbol when TAIL_EN=1;
- the in_last data symbol when TAIL_EN=0.
REQ-023 When TAIL_EN=0, in_last does not change the FSM or state. The next frame continues from the current state.
REQ-024 Full throughput: one symbol per cycle when out_ready is held at 1. The cycle-by-cycle pattern is in the next line.
REQ-025 With out_ready=1: out_valid stays 1 with no bubbles between data and tail. in_ready is 0 for exactly two cycles per frame.
REQ-026 An output register drained with no new load in the same cycle sets out_valid=0.

Reset
REQ-027 On reset the following SHALL hold in the next cycle:
- FSM=DATA;
- enc_state=00;
- out_valid=0, out_sym=0, out_last=0;
- in_ready=1.
REQ-028 Reset asserted mid-frame or mid-tail discards the pending symbol and any remaining tail symbols.

Structure
REQ-029 A shared package holds:
- the FSM state enum;
- symbol width 3 and state width 2 constants;
- the next-state/label function, so decoder-side models use the same trellis definition.
REQ-030 One sub-module, tcm_out_reg: the symbol register with valid/ready. The rest is flat.

Verification
REQ-031 Basic frame. Reset, out_ready=1, inputs 01,10,00,01 with last on the 4th -> out_sym 2,5,0,3, then tails 3,2. out_last only on 2. enc_state ends at 00.
REQ-032 Single-symbol frame. Input 11 with in_last -> syms 6,1,2. out_last on 2. in_ready low for the two tail cycles.
REQ-033 Backpressure. out_ready=0 for 3 cycles after the first symbol -> out_sym stays 2 and in_ready=0. Once released, the sequence continues unchanged.
REQ-034 TAIL_EN=0. Inputs 01,10 with last on the 2nd -> syms 2,5, out_last on 5, no tail. enc_state=10, and the next frame starts from it.
REQ-035 Reset during TAIL1 -> next cycle out_valid=0, enc_state=00, in_ready=1. No further tail symbols.
